// File: rtl/multi_obj_motion.sv
// Time-multiplexed motion engine: one sweep per frame tick, one object per clock.
// Positions and velocities are fixed point with XY_FRACTION fractional bits.
module multi_obj_motion #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned NUM_OBJ     = 8,
  parameter int unsigned XY_FRACTION = 16,
  parameter int unsigned SPEED_W     = 24,
  parameter int unsigned DRAG_SHIFT  = 0,
  parameter int unsigned DIVIDER     = 125_000,
  localparam int unsigned X_W        = $clog2(WIDTH),
  localparam int unsigned Y_W        = $clog2(HEIGHT),
  localparam int unsigned IDX_W      = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [IDX_W-1:0]          load_idx,
  input  logic [X_W-1:0]            load_x,
  input  logic [Y_W-1:0]            load_y,
  input  logic [SPEED_W-1:0]        load_vx,
  input  logic [SPEED_W-1:0]        load_vy,
  input  logic                      load_wrap,
  input  logic                      accel_valid,
  input  logic [IDX_W-1:0]          accel_idx,
  input  logic [SPEED_W-1:0]        accel_dx,
  input  logic [SPEED_W-1:0]        accel_dy,
  input  logic [NUM_OBJ-1:0]        kill,
  output logic [NUM_OBJ-1:0]        active,
  output logic [NUM_OBJ*X_W-1:0]    pos_x,
  output logic [NUM_OBJ*Y_W-1:0]    pos_y,
  output logic                      frame_done
);

  localparam int unsigned PXW   = X_W + XY_FRACTION;
  localparam int unsigned PYW   = Y_W + XY_FRACTION;
  localparam int unsigned CNT_W = $clog2(DIVIDER);

  localparam logic [CNT_W-1:0] CntMax   = CNT_W'(DIVIDER - 1);
  localparam logic [IDX_W-1:0] SlotLast = IDX_W'(NUM_OBJ - 1);

  localparam logic signed [SPEED_W-1:0] VMax = {1'b0, {(SPEED_W-1){1'b1}}};
  localparam logic signed [SPEED_W-1:0] VMin = {1'b1, {(SPEED_W-1){1'b0}}};

  // Screen extent in fixed point, two guard bits for the signed sum
  localparam logic signed [PXW+1:0] XSpan = {1'b0, (X_W+1)'(WIDTH), {XY_FRACTION{1'b0}}};
  localparam logic signed [PYW+1:0] YSpan = {1'b0, (Y_W+1)'(HEIGHT), {XY_FRACTION{1'b0}}};

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  function automatic logic signed [SPEED_W-1:0] sat_add(input logic signed [SPEED_W-1:0] a,
                                                        input logic signed [SPEED_W-1:0] b);
    logic signed [SPEED_W:0] s;
    s = {a[SPEED_W-1], a} + {b[SPEED_W-1], b};
    if (s[SPEED_W] != s[SPEED_W-1]) sat_add = s[SPEED_W] ? VMin : VMax;
    else                            sat_add = s[SPEED_W-1:0];
  endfunction

  // Pending accel, then drag, then symmetric clamp so the velocity never reaches VMin
  function automatic logic signed [SPEED_W-1:0] vel_step(input logic signed [SPEED_W-1:0] v,
                                                         input logic signed [SPEED_W-1:0] pe);
    logic signed [SPEED_W-1:0] v1;
    logic signed [SPEED_W-1:0] v2;
    v1 = sat_add(v, pe);
    if (DRAG_SHIFT > 0) v2 = v1 - (v1 >>> DRAG_SHIFT);
    else                v2 = v1;
    if (v2 == VMin) v2 = -VMax;
    vel_step = v2;
  endfunction

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   slot_q;
  logic               frame_done_q;
  logic               load_ready_q;

  logic [PXW-1:0]            px_q   [NUM_OBJ];
  logic [PYW-1:0]            py_q   [NUM_OBJ];
  logic signed [SPEED_W-1:0] vx_q   [NUM_OBJ];
  logic signed [SPEED_W-1:0] vy_q   [NUM_OBJ];
  logic signed [SPEED_W-1:0] pex_q  [NUM_OBJ];
  logic signed [SPEED_W-1:0] pey_q  [NUM_OBJ];
  logic [NUM_OBJ-1:0]        wrap_q;
  logic [NUM_OBJ-1:0]        active_q;

  // Frame timer and sweep sequencer
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      slot_q       <= '0;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      cnt_q        <= (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
      frame_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cnt_q == CntMax) begin
            state_q      <= StSweep;
            slot_q       <= '0;
            load_ready_q <= 1'b0;
          end
        end
        StSweep: begin
          if (slot_q == SlotLast) begin
            state_q      <= StDone;
            frame_done_q <= 1'b1;
            load_ready_q <= 1'b1;
          end else begin
            slot_q <= slot_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  logic                      in_sweep;
  logic                      load_acc;
  logic [X_W-1:0]            load_x_c;
  logic [Y_W-1:0]            load_y_c;
  logic                      acc_hit;
  logic signed [SPEED_W-1:0] pex_eff;
  logic signed [SPEED_W-1:0] pey_eff;
  logic signed [SPEED_W-1:0] vx_new;
  logic signed [SPEED_W-1:0] vy_new;
  logic signed [PXW+1:0]     px_sum;
  logic signed [PYW+1:0]     py_sum;
  logic signed [PXW+1:0]     px_fix;
  logic signed [PYW+1:0]     py_fix;
  logic                      x_low, x_high, y_low, y_high;
  logic                      slot_out;

  // Load clamping and the shared per-slot update datapath
  always_comb begin
    in_sweep = (state_q == StSweep);
    load_acc = load_valid && load_ready_q;
    load_x_c = ({1'b0, load_x} >= (X_W+1)'(WIDTH))  ? X_W'(WIDTH - 1)  : load_x;
    load_y_c = ({1'b0, load_y} >= (Y_W+1)'(HEIGHT)) ? Y_W'(HEIGHT - 1) : load_y;

    acc_hit = accel_valid && (accel_idx == slot_q);
    pex_eff = sat_add(pex_q[slot_q], acc_hit ? accel_dx : '0);
    pey_eff = sat_add(pey_q[slot_q], acc_hit ? accel_dy : '0);
    vx_new  = vel_step(vx_q[slot_q], pex_eff);
    vy_new  = vel_step(vy_q[slot_q], pey_eff);

    px_sum = {2'b00, px_q[slot_q]} + {{(PXW+2-SPEED_W){vx_new[SPEED_W-1]}}, vx_new};
    py_sum = {2'b00, py_q[slot_q]} + {{(PYW+2-SPEED_W){vy_new[SPEED_W-1]}}, vy_new};

    x_low  = px_sum[PXW+1];
    x_high = !x_low && (px_sum >= XSpan);
    y_low  = py_sum[PYW+1];
    y_high = !y_low && (py_sum >= YSpan);

    px_fix = x_low ? px_sum + XSpan : (x_high ? px_sum - XSpan : px_sum);
    py_fix = y_low ? py_sum + YSpan : (y_high ? py_sum - YSpan : py_sum);

    slot_out = x_low || x_high || y_low || y_high;
  end

  // Per-object state: load beats kill, kill beats the slot update
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        px_q[i]  <= '0;
        py_q[i]  <= '0;
        vx_q[i]  <= '0;
        vy_q[i]  <= '0;
        pex_q[i] <= '0;
        pey_q[i] <= '0;
      end
      wrap_q   <= '0;
      active_q <= '0;
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (load_acc && (load_idx == IDX_W'(i))) begin
          px_q[i]     <= {load_x_c, {XY_FRACTION{1'b0}}};
          py_q[i]     <= {load_y_c, {XY_FRACTION{1'b0}}};
          vx_q[i]     <= load_vx;
          vy_q[i]     <= load_vy;
          pex_q[i]    <= '0;
          pey_q[i]    <= '0;
          wrap_q[i]   <= load_wrap;
          active_q[i] <= 1'b1;
        end else begin
          if (kill[i]) active_q[i] <= 1'b0;
          if (in_sweep && (slot_q == IDX_W'(i)) && active_q[i] && !kill[i]) begin
            pex_q[i] <= '0;
            pey_q[i] <= '0;
            if (slot_out && !wrap_q[i]) begin
              active_q[i] <= 1'b0;
            end else begin
              px_q[i] <= px_fix[PXW-1:0];
              py_q[i] <= py_fix[PYW-1:0];
              vx_q[i] <= vx_new;
              vy_q[i] <= vy_new;
            end
          end else if (accel_valid && (accel_idx == IDX_W'(i)) && active_q[i]) begin
            pex_q[i] <= sat_add(pex_q[i], accel_dx);
            pey_q[i] <= sat_add(pey_q[i], accel_dy);
          end
        end
      end
    end
  end

  // Integer parts of the registered positions
  always_comb begin
    pos_x = '0;
    pos_y = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      pos_x[i*X_W +: X_W] = px_q[i][PXW-1 -: X_W];
      pos_y[i*Y_W +: Y_W] = py_q[i][PYW-1 -: Y_W];
    end
  end

  assign active     = active_q;
  assign frame_done = frame_done_q;
  assign load_ready = load_ready_q;

endmodule
